// File: rtl/cadc_bus_initiator.sv
// Host-side initiator for the CADC 20-bit processor bus: expands LOAD/STORE/READ
// commands into timed bus cycles and returns one response word per command.
module cadc_bus_initiator #(
  parameter int unsigned   DW        = 20,
  parameter int unsigned   AW        = 20,
  parameter int unsigned   RD_LAT    = 1,
  parameter logic [AW-1:0] IDLE_ADDR = {AW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_kind,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [6:0]    cmd_addr,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          busy,
  output logic [15:0]   txn_count
);

  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {
    IDLE, WR_OP, WR_A, WR_B, WR_ST, RD_ADDR, RD_WAIT, RSP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, b_q;
  logic [6:0]    addr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] bus_addr_d;
  logic [DW-1:0] bus_wdata_d, rsp_data_d;
  logic          rsp_err_d;
  logic [15:0]   txn_count_d;
  logic          accept, rsp_hs;

  assign accept = (state_q == IDLE) && cmd_valid;
  assign rsp_hs = (state_q == RSP) && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_kind)
            2'b00:   state_d = WR_OP;
            2'b01:   state_d = WR_ST;
            2'b10:   state_d = RD_ADDR;
            default: state_d = RSP;
          endcase
        end
      end
      WR_OP:   state_d = WR_A;
      WR_A:    state_d = WR_B;
      WR_B:    state_d = RSP;
      WR_ST:   state_d = RSP;
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: if (cnt_q == '0) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: bus values are a function of the state being entered
  always_comb begin
    bus_addr_d  = IDLE_ADDR;
    bus_wdata_d = '0;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    txn_count_d = txn_count;
    case (state_d)
      WR_OP:   begin bus_addr_d = '0;        bus_wdata_d = DW'(cmd_op); end
      WR_A:    begin bus_addr_d = AW'(1);    bus_wdata_d = a_q;         end
      WR_B:    begin bus_addr_d = AW'(2);    bus_wdata_d = b_q;         end
      WR_ST:   begin bus_addr_d = AW'(3);    bus_wdata_d = cmd_a;       end
      RD_ADDR: bus_addr_d = AW'(cmd_addr);
      RD_WAIT: bus_addr_d = AW'(addr_q);
      default: ;
    endcase
    if (state_q == RD_ADDR)
      cnt_d = CW'(RD_LAT - 1);
    else if ((state_q == RD_WAIT) && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
    if (accept) begin
      rsp_data_d = '0;
      rsp_err_d  = (cmd_kind == 2'b11);
    end
    if ((state_q == RD_WAIT) && (cnt_q == '0))
      rsp_data_d = bus_rdata;
    if (rsp_hs) begin
      rsp_err_d   = 1'b0;
      txn_count_d = txn_count + 16'd1;
    end
  end

  // Registered outputs and captured command fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr  <= IDLE_ADDR;
      bus_wdata <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      txn_count <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      addr_q    <= '0;
    end else begin
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      cmd_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RSP);
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      busy      <= (state_d != IDLE);
      txn_count <= txn_count_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        a_q    <= cmd_a;
        b_q    <= cmd_b;
        addr_q <= cmd_addr;
      end
    end
  end

endmodule

// File: tb/tb_cadc_bus_initiator.sv
// Self-checking bench for cadc_bus_initiator with a delayed-memory core model.
module tb_cadc_bus_initiator;

  localparam logic [19:0] IDLE = 20'hFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd3_valid = 1'b0;
  logic [1:0]  cmd_kind = 2'b00;
  logic [2:0]  cmd_op = 3'b000;
  logic [19:0] cmd_a = '0, cmd_b = '0;
  logic [6:0]  cmd_addr = '0;
  logic        rsp_ready = 1'b0, rsp3_ready = 1'b0;

  logic        cmd_ready, rsp_valid, rsp_err, busy;
  logic [19:0] bus_addr, bus_wdata, bus_rdata, rsp_data;
  logic [15:0] txn_count;
  logic        cmd3_ready, rsp3_valid, rsp3_err, busy3;
  logic [19:0] bus3_addr, bus3_wdata, bus3_rdata, rsp3_data;
  logic [15:0] txn3_count;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] exp_cnt3 = '0;
  logic [19:0] mem [128];
  logic [19:0] p1, q1, q2, q3;

  always #5 clk = ~clk;

  cadc_bus_initiator #(.RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_addr(cmd_addr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .txn_count(txn_count)
  );

  cadc_bus_initiator #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd3_valid), .cmd_ready(cmd3_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_addr(cmd_addr), .bus_addr(bus3_addr), .bus_wdata(bus3_wdata),
    .bus_rdata(bus3_rdata), .rsp_valid(rsp3_valid), .rsp_ready(rsp3_ready),
    .rsp_data(rsp3_data), .rsp_err(rsp3_err), .busy(busy3), .txn_count(txn3_count)
  );

  // Core model: memory word for the address seen N edges ago; anything else is garbage
  function automatic logic [19:0] lookup(input logic [19:0] a);
    if (a[19:7] == 13'd0) return mem[a[6:0]];
    return ~mem[cmd_addr];
  endfunction

  always @(posedge clk) begin
    p1 <= lookup(bus_addr);
    q1 <= lookup(bus3_addr);
    q2 <= q1;
    q3 <= q2;
  end
  assign bus_rdata  = p1;
  assign bus3_rdata = q3;

  // One complete command on the RD_LAT=1 instance; called at posedge+1
  task automatic txn(input logic [1:0] kind, input logic [2:0] op, input logic [19:0] a,
                     input logic [19:0] b, input logic [6:0] addr, input int hold, input bit stall);
    logic [19:0] ea[$];
    logic [19:0] ew[$];
    logic [19:0] edata;
    edata = '0;
    case (kind)
      2'b00: begin ea = {20'd0, 20'd1, 20'd2}; ew = {20'(op), a, b}; end
      2'b01: begin ea = {20'd3}; ew = {a}; end
      2'b10: begin
        for (int i = 0; i < 2; i++) begin ea.push_back(20'(addr)); ew.push_back(20'd0); end
        edata = mem[addr];
      end
      default: ;
    endcase
    cmd_kind = kind; cmd_op = op; cmd_a = a; cmd_b = b; cmd_addr = addr; cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: cmd_ready=%b required 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    foreach (ea[i]) begin
      checks++;
      if (bus_addr !== ea[i] || bus_wdata !== ew[i]) begin
        errors++;
        $display("FAIL bus_cycle%0d kind%0d: addr=%h wdata=%h required addr=%h wdata=%h",
                 i, kind, bus_addr, bus_wdata, ea[i], ew[i]);
      end
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_flags: rsp_valid=%b busy=%b cmd_ready=%b required 0 1 0", rsp_valid, busy, cmd_ready);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== edata || rsp_err !== (kind == 2'b11)) begin
      errors++;
      $display("FAIL response kind%0d: valid=%b data=%h err=%b required 1 %h %b",
               kind, rsp_valid, rsp_data, rsp_err, edata, kind == 2'b11);
    end
    checks++;
    if (bus_addr !== IDLE || bus_wdata !== 20'd0) begin
      errors++; $display("FAIL bus_idle_rsp: addr=%h wdata=%h required %h 0", bus_addr, bus_wdata, IDLE);
    end
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      if (stall) begin
        cmd_kind = 2'b00; cmd_op = 3'b101; cmd_a = 20'h55555; cmd_b = 20'h0AAAA; cmd_valid = 1'b1;
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== edata || cmd_ready !== 1'b0 || bus_addr !== IDLE) begin
        errors++;
        $display("FAIL hold%0d: valid=%b data=%h ready=%b addr=%h required 1 %h 0 %h",
                 i, rsp_valid, rsp_data, cmd_ready, bus_addr, edata, IDLE);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 ||
        txn_count !== exp_cnt || bus_addr !== IDLE) begin
      errors++;
      $display("FAIL after_hs: valid=%b err=%b ready=%b busy=%b count=%h addr=%h required 0 0 1 0 %h %h",
               rsp_valid, rsp_err, cmd_ready, busy, txn_count, bus_addr, exp_cnt, IDLE);
    end
    if (kind == 2'b01) mem[3] = a;
  endtask

  // One READ on the RD_LAT=3 instance
  task automatic rd3(input logic [6:0] addr);
    cmd_kind = 2'b10; cmd_addr = addr; cmd3_valid = 1'b1;
    @(posedge clk); #1;
    cmd3_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus3_addr !== 20'(addr) || bus3_wdata !== 20'd0 || rsp3_valid !== 1'b0) begin
        errors++;
        $display("FAIL rd3_cycle%0d: addr=%h wdata=%h valid=%b required %h 0 0",
                 i, bus3_addr, bus3_wdata, rsp3_valid, 20'(addr));
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rsp3_valid !== 1'b1 || rsp3_data !== mem[addr] || rsp3_err !== 1'b0 || bus3_addr !== IDLE) begin
      errors++;
      $display("FAIL rd3_rsp: valid=%b data=%h err=%b addr=%h required 1 %h 0 %h",
               rsp3_valid, rsp3_data, rsp3_err, bus3_addr, mem[addr], IDLE);
    end
    rsp3_ready = 1'b1;
    @(posedge clk); #1;
    rsp3_ready = 1'b0;
    exp_cnt3 = exp_cnt3 + 16'd1;
    checks++;
    if (rsp3_valid !== 1'b0 || txn3_count !== exp_cnt3 || cmd3_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd3_hs: valid=%b count=%h ready=%b required 0 %h 1", rsp3_valid, txn3_count, cmd3_ready, exp_cnt3);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_addr !== IDLE || bus_wdata !== 20'd0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        rsp_data !== 20'd0 || rsp_err !== 1'b0 || busy !== 1'b0 || txn_count !== 16'd0) begin
      errors++;
      $display("FAIL reset: addr=%h wdata=%h ready=%b valid=%b data=%h err=%b busy=%b count=%h required idle values",
               bus_addr, bus_wdata, cmd_ready, rsp_valid, rsp_data, rsp_err, busy, txn_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    txn(2'b00, 3'b001, 20'h00123, 20'h00023, 7'd0, 0, 1'b0);
    for (int i = 0; i < 6; i++)
      txn(2'b00, 3'($urandom), 20'($urandom), 20'($urandom), 7'($urandom), 0, 1'b0);
  endtask

  task automatic test_store_read();
    txn(2'b01, 3'd0, 20'hABCDE, 20'd0, 7'd0, 0, 1'b0);
    txn(2'b10, 3'd0, 20'd0, 20'd0, 7'd3, 0, 1'b0);
    checks++;
    if (rsp_data !== 20'hABCDE) begin errors++; $display("FAIL store_read: data=%h required ABCDE", rsp_data); end
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(1) == 0) txn(2'b01, 3'd0, 20'($urandom), 20'd0, 7'd0, 0, 1'b0);
      else                        txn(2'b10, 3'd0, 20'd0, 20'd0, 7'($urandom), 0, 1'b0);
    end
  endtask

  task automatic test_read_lat3();
    rd3(7'd3);
    for (int i = 0; i < 6; i++) rd3(7'($urandom));
  endtask

  task automatic test_backpressure();
    txn(2'b01, 3'd0, 20'($urandom), 20'd0, 7'd0, 10, 1'b1);
    txn(2'b00, 3'b101, 20'h55555, 20'h0AAAA, 7'd0, 0, 1'b0);
  endtask

  task automatic test_reserved();
    txn(2'b11, 3'($urandom), 20'($urandom), 20'($urandom), 7'($urandom), 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    cmd_kind = 2'b00; cmd_op = 3'b110; cmd_a = 20'h13579; cmd_b = 20'h2468A; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_addr !== 20'd1 || bus_wdata !== 20'h13579) begin
      errors++; $display("FAIL mid_wr_a: addr=%h wdata=%h required 1 13579", bus_addr, bus_wdata);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_addr !== IDLE || bus_wdata !== 20'd0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 ||
        busy !== 1'b0 || txn_count !== 16'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: addr=%h wdata=%h ready=%b valid=%b busy=%b count=%h required idle values",
               bus_addr, bus_wdata, cmd_ready, rsp_valid, busy, txn_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    exp_cnt3 = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || bus_addr !== IDLE) begin
        errors++; $display("FAIL post_reset%0d: valid=%b addr=%h required 0 %h", i, rsp_valid, bus_addr, IDLE);
      end
    end
  endtask

  task automatic test_wrap();
    force dut.txn_count = 16'hFFFF;
    #2;
    release dut.txn_count;
    exp_cnt = 16'hFFFF;
    @(posedge clk); #1;
    checks++;
    if (txn_count !== 16'hFFFF) begin errors++; $display("FAIL preload: count=%h required ffff", txn_count); end
    txn(2'b11, 3'd0, 20'd0, 20'd0, 7'd0, 0, 1'b0);
    checks++;
    if (txn_count !== 16'd0) begin errors++; $display("FAIL wrap: count=%h required 0", txn_count); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 20'($urandom);
    test_reset();
    test_load();
    test_store_read();
    test_read_lat3();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
